// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared widths, command opcodes, operand addresses and the
// sequencer state encoding for sys_ctrl. The ALU states only exist when
// SYS_CTRL_ALU_CMD_EN is defined.
package sys_ctrl_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int FUN_WIDTH  = 4;

  localparam logic [DATA_WIDTH-1:0] CMD_WR      = 8'hAA;
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = 8'hBB;
  localparam logic [DATA_WIDTH-1:0] CMD_ALU     = 8'hCC;
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = 4'd0;
  localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = 4'd1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_SEND
`ifdef SYS_CTRL_ALU_CMD_EN
    ,
    ST_OPA,
    ST_OPB,
    ST_FUN,
    ST_ALU_WAIT,
    ST_SEND_LO,
    ST_SEND_HI
`endif
  } state_e;

  // Address bytes wider than the register file simply wrap.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [DATA_WIDTH-1:0] b);
    return b[ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sys_ctrl_if.sv
// sys_ctrl_if: RX byte stream, register-file port, ALU port and TX FIFO push
// port of the command sequencer. master = sys_ctrl, slave = its environment.
interface sys_ctrl_if;
  import sys_ctrl_pkg::*;

  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [ADDR_WIDTH-1:0]   Address;
  logic                    WrEn;
  logic                    RdEn;
  logic [DATA_WIDTH-1:0]   WrData;
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_Valid;
  logic                    ALU_EN;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    CLK_GATE_EN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic                    FIFO_FULL;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    output Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    input  Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
  );

endinterface

// File: rtl/sys_ctrl.sv
// sys_ctrl: command sequencer between the UART RX byte stream, the register
// file, the ALU and the TX FIFO. All outputs are registered and reset to 0.
// Optional feature macro: SYS_CTRL_ALU_CMD_EN (0xCC / 0xDD ALU commands).
module sys_ctrl
  import sys_ctrl_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  sys_ctrl_if.master   bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tx_vld_q, tx_vld_d;
`ifdef SYS_CTRL_ALU_CMD_EN
  logic                    alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic                    clk_gate_q, clk_gate_d;
  logic [2*DATA_WIDTH-1:0] alu_res_q, alu_res_d;
`endif

  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  rx_vld;
  assign rx_byte = bus.RX_P_DATA;
  assign rx_vld  = bus.RX_D_VLD;

  // Next-state and next-output decode for the command sequencer.
  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred; strobes default to 0, data holds.
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_data_d = rd_data_q;
    address_d = address_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
`ifdef SYS_CTRL_ALU_CMD_EN
    alu_en_d  = 1'b0;
    alu_fun_d = alu_fun_q;
    alu_res_d = alu_res_q;
`endif
    case (state_q)
      ST_IDLE: if (rx_vld) begin
        case (rx_byte)
          CMD_WR:      state_d = ST_WR_ADDR;
          CMD_RD:      state_d = ST_RD_ADDR;
`ifdef SYS_CTRL_ALU_CMD_EN
          CMD_ALU:     state_d = ST_OPA;
          CMD_ALU_NOP: state_d = ST_FUN;
`endif
          default:     state_d = ST_IDLE;
        endcase
      end
      ST_WR_ADDR: if (rx_vld) begin
        wr_addr_d = addr_of(rx_byte);
        state_d   = ST_WR_DATA;
      end
      ST_WR_DATA: if (rx_vld) begin
        wr_en_d   = 1'b1;
        address_d = wr_addr_q;
        wr_data_d = rx_byte;
        state_d   = ST_IDLE;
      end
      ST_RD_ADDR: if (rx_vld) begin
        rd_en_d   = 1'b1;
        address_d = addr_of(rx_byte);
        state_d   = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (bus.RdData_Valid) begin
        rd_data_d = bus.RdData;
        state_d   = ST_RD_SEND;
      end
      ST_RD_SEND: if (!bus.FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = rd_data_q;
        state_d   = ST_IDLE;
      end
`ifdef SYS_CTRL_ALU_CMD_EN
      ST_OPA: if (rx_vld) begin
        wr_en_d   = 1'b1;
        address_d = OPA_ADDR;
        wr_data_d = rx_byte;
        state_d   = ST_OPB;
      end
      ST_OPB: if (rx_vld) begin
        wr_en_d   = 1'b1;
        address_d = OPB_ADDR;
        wr_data_d = rx_byte;
        state_d   = ST_FUN;
      end
      ST_FUN: if (rx_vld) begin
        alu_en_d  = 1'b1;
        alu_fun_d = rx_byte[FUN_WIDTH-1:0];
        state_d   = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: if (bus.ALU_OUT_VLD) begin
        alu_res_d = bus.ALU_OUT;
        state_d   = ST_SEND_LO;
      end
      ST_SEND_LO: if (!bus.FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = alu_res_q[DATA_WIDTH-1:0];
        state_d   = ST_SEND_HI;
      end
      ST_SEND_HI: if (!bus.FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        state_d   = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef SYS_CTRL_ALU_CMD_EN
    // Gate stays open while the registered state is anywhere from FUN to SEND_HI.
    clk_gate_d = (state_d inside {ST_FUN, ST_ALU_WAIT, ST_SEND_LO, ST_SEND_HI});
`endif
  end

  // State, capture and output registers; reset aborts any command in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      rd_data_q  <= '0;
      address_q  <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_vld_q   <= 1'b0;
`ifdef SYS_CTRL_ALU_CMD_EN
      alu_en_q   <= 1'b0;
      alu_fun_q  <= '0;
      clk_gate_q <= 1'b0;
      alu_res_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_data_q  <= rd_data_d;
      address_q  <= address_d;
      wr_data_q  <= wr_data_d;
      tx_data_q  <= tx_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      tx_vld_q   <= tx_vld_d;
`ifdef SYS_CTRL_ALU_CMD_EN
      alu_en_q   <= alu_en_d;
      alu_fun_q  <= alu_fun_d;
      clk_gate_q <= clk_gate_d;
      alu_res_q  <= alu_res_d;
`endif
    end
  end

  assign bus.Address   = address_q;
  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.WrData    = wr_data_q;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
`ifdef SYS_CTRL_ALU_CMD_EN
  assign bus.ALU_EN      = alu_en_q;
  assign bus.ALU_FUN     = alu_fun_q;
  assign bus.CLK_GATE_EN = clk_gate_q;
`else
  assign bus.ALU_EN      = 1'b0;
  assign bus.ALU_FUN     = '0;
  assign bus.CLK_GATE_EN = 1'b0;
  // ALU result port is unused when the ALU commands are not built.
  logic unused_alu;
  assign unused_alu = ^{bus.ALU_OUT, bus.ALU_OUT_VLD};
`endif

endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed test of sys_ctrl with a register-file / ALU responder
// model and scoreboard queues for expected writes, reads, ALU ops and TX bytes.
module tb_sys_ctrl;
  import sys_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sys_ctrl_if bus();

  sys_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_wr[$];   // {addr, data}
  logic [3:0]  exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [3:0]  exp_fun[$];
  int tx_seen = 0;
  int wr_seen = 0;
  logic [7:0] mem [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Register file and ALU responder: read data and ALU result one cycle after the strobe.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hA0 + 8'(i);
      bus.RdData       <= '0;
      bus.RdData_Valid <= 1'b0;
      bus.ALU_OUT      <= '0;
      bus.ALU_OUT_VLD  <= 1'b0;
    end else begin
      if (bus.WrEn) mem[bus.Address] <= bus.WrData;
      bus.RdData_Valid <= bus.RdEn;
      if (bus.RdEn) bus.RdData <= mem[bus.Address];
      bus.ALU_OUT_VLD <= bus.ALU_EN;
      if (bus.ALU_EN)
        bus.ALU_OUT <= (bus.ALU_FUN == 4'd0) ? ({8'h00, mem[0]} + {8'h00, mem[1]}) : 16'h0000;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.WrEn || bus.RdEn) check("wr_rd_exclusive", {31'd0, bus.WrEn & bus.RdEn}, 32'd0);
      if (bus.WrEn) begin
        wr_seen++;
        check("wr_expected", {31'd0, exp_wr.size() > 0}, 32'd1);
        if (exp_wr.size() > 0) check("wr_addr_data", {20'd0, bus.Address, bus.WrData}, {20'd0, exp_wr.pop_front()});
      end
      if (bus.RdEn) begin
        check("rd_expected", {31'd0, exp_rd.size() > 0}, 32'd1);
        if (exp_rd.size() > 0) check("rd_addr", {28'd0, bus.Address}, {28'd0, exp_rd.pop_front()});
      end
      if (bus.TX_D_VLD) begin
        tx_seen++;
        check("tx_expected", {31'd0, exp_tx.size() > 0}, 32'd1);
        if (exp_tx.size() > 0) check("tx_data", {24'd0, bus.TX_P_DATA}, {24'd0, exp_tx.pop_front()});
      end
      if (bus.ALU_EN) begin
        check("alu_expected", {31'd0, exp_fun.size() > 0}, 32'd1);
        if (exp_fun.size() > 0) check("alu_fun", {28'd0, bus.ALU_FUN}, {28'd0, exp_fun.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(negedge CLK);
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_tx.size() + exp_fun.size()) != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(tag, exp_wr.size() + exp_rd.size() + exp_tx.size() + exp_fun.size(), 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  function automatic logic [31:0] out_vec();
    return {bus.Address, bus.WrEn, bus.RdEn, bus.WrData, bus.ALU_EN, bus.ALU_FUN,
            bus.CLK_GATE_EN, bus.TX_D_VLD, bus.TX_P_DATA[3:0]};
  endfunction

  initial begin
    int base;
    bus.RX_P_DATA = '0;
    bus.RX_D_VLD  = 1'b0;
    bus.FIFO_FULL = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_outputs", out_vec(), 32'd0);
    check("reset_tx_data", {24'd0, bus.TX_P_DATA}, 32'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Plain write
    exp_wr.push_back({4'h5, 8'h3C});
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    drain("drain_write");
    check("write_count", wr_seen, 32'd1);

    // Read back, then read through a wrapped address byte
    exp_rd.push_back(4'h5); exp_tx.push_back(8'h3C);
    send_byte(8'hBB); send_byte(8'h05);
    drain("drain_read");
    exp_rd.push_back(4'h5); exp_tx.push_back(8'h3C);
    send_byte(8'hBB); send_byte(8'h15);
    drain("drain_read_wrap");

    // TX push held off while the FIFO is full
    exp_wr.push_back({4'h2, 8'h81});
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h81);
    drain("drain_write2");
    bus.FIFO_FULL = 1'b1;
    exp_rd.push_back(4'h2);
    base = tx_seen;
    send_byte(8'hBB); send_byte(8'h02);
    repeat (10) @(negedge CLK);
    check("full_no_push", tx_seen, base);
    exp_tx.push_back(8'h81);
    bus.FIFO_FULL = 1'b0;
    drain("drain_full");
    check("full_single_push", tx_seen, base + 1);

    // Unknown opcode ignored, next command unaffected
    base = wr_seen;
    send_byte(8'h55);
    repeat (4) @(negedge CLK);
    check("unknown_no_write", wr_seen, base);
    exp_wr.push_back({4'h1, 8'hFF});
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    drain("drain_after_unknown");

`ifdef SYS_CTRL_ALU_CMD_EN
    // ALU add through operand registers
    exp_wr.push_back({OPA_ADDR, 8'h0A});
    exp_wr.push_back({OPB_ADDR, 8'h03});
    exp_fun.push_back(4'h0);
    exp_tx.push_back(8'h0D); exp_tx.push_back(8'h00);
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03);
    check("gate_on_in_fun", {31'd0, bus.CLK_GATE_EN}, 32'd1);
    send_byte(8'h00);
    drain("drain_alu");
    check("gate_off_after", {31'd0, bus.CLK_GATE_EN}, 32'd0);
`else
    // ALU commands are unknown in this build
    base = wr_seen;
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'hDD); send_byte(8'h07);
    repeat (4) @(negedge CLK);
    check("alu_cmd_ignored", wr_seen, base);
    check("alu_outputs_zero", {27'd0, bus.ALU_EN, bus.ALU_FUN != 4'd0, bus.CLK_GATE_EN, 2'd0}, 32'd0);
    exp_wr.push_back({4'h4, 8'h11});
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h11);
    drain("drain_after_alu_cmd");
`endif

    // Reset mid-command, then a clean read of the default value
    send_byte(8'hAA); send_byte(8'h03);
    RST = 1'b0;
    @(negedge CLK);
    check("midreset_outputs", out_vec(), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    base = wr_seen;
    exp_rd.push_back(4'h3); exp_tx.push_back(8'hA3);
    send_byte(8'hBB); send_byte(8'h03);
    drain("drain_post_reset");
    check("post_reset_no_write", wr_seen, base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
